imm_gen_pipe: RTL and testbench

Registered, flow-controlled immediate generator for the decode stage of the RV32I core. It is the XLEN-parametrised successor of the combinational immediate generator and adds three things: a valid/ready handshake with a 2-entry skid buffer, shift-amount and zero immediate types, and an illegal-encoding flag. It sits between the instruction-fetch/decode boundary and the execute operand mux, and carries a sideband tag (PC or ROB index) alongside each result.

---
 rtl/imm_gen_pipe_if.sv | 42 ++++
 rtl/imm_gen_pipe.sv | 93 +++++++++
 tb/tb_imm_gen_pipe.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/imm_gen_pipe_if.sv
// rtl/imm_gen_pipe_if.sv - handshake bundle between decode, imm_gen_pipe and the execute operand mux
interface imm_gen_pipe_if #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 32
);
    logic [31:0]      instr_in;
    logic [3:0]       imm_type_in;
    logic [TAG_W-1:0] tag_in;
    logic             in_valid_in;
    logic             in_ready_out;
    logic [XLEN-1:0]  imm_out;
    logic [TAG_W-1:0] tag_out;
    logic             err_out;
    logic             out_valid_out;
    logic             out_ready_in;

    modport slave (
        input  instr_in,
        input  imm_type_in,
        input  tag_in,
        input  in_valid_in,
        output in_ready_out,
        output imm_out,
        output tag_out,
        output err_out,
        output out_valid_out,
        input  out_ready_in
    );

    modport master (
        output instr_in,
        output imm_type_in,
        output tag_in,
        output in_valid_in,
        input  in_ready_out,
        input  imm_out,
        input  tag_out,
        input  err_out,
        input  out_valid_out,
        output out_ready_in
    );
endinterface

// File: rtl/imm_gen_pipe.sv
// rtl/imm_gen_pipe.sv - registered RV32I/RV64I immediate generator with 2-entry skid buffer
module imm_gen_pipe #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 32
) (
    input  logic          clk_in,
    input  logic          rst_in,
    imm_gen_pipe_if.slave bus
);
    logic [31:0]      instr;
    logic [XLEN-1:0]  imm_c;
    logic             err_c;
    logic             unused_opcode;

    logic             out_valid;
    logic [XLEN-1:0]  out_imm;
    logic [TAG_W-1:0] out_tag;
    logic             out_err;
    logic             skid_valid;
    logic [XLEN-1:0]  skid_imm;
    logic [TAG_W-1:0] skid_tag;
    logic             skid_err;

    logic             in_fire;
    logic             out_fire;

    assign instr         = bus.instr_in;
    assign unused_opcode = ^instr[6:0];

    always_comb begin
        imm_c = '0;
        err_c = 1'b0;
        case (bus.imm_type_in)
            4'd0, 4'd1, 4'd7: imm_c = XLEN'($signed(instr[31:20]));
            4'd2: imm_c = XLEN'($signed({instr[31:25], instr[11:7]}));
            4'd3: imm_c = XLEN'($signed({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}));
            4'd4: imm_c = XLEN'($signed({instr[31:12], 12'b0}));
            4'd5: imm_c = XLEN'($signed({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}));
            4'd6: imm_c = XLEN'(instr[19:15]);
            4'd8: begin
                // RV32 shifts above 31 are flagged but still yield the low five bits
                if (XLEN == 32) begin
                    imm_c = XLEN'(instr[24:20]);
                    err_c = instr[25];
                end else begin
                    imm_c = XLEN'(instr[25:20]);
                end
            end
            4'd9: imm_c = '0;
            default: err_c = 1'b1;
        endcase
    end

    assign in_fire  = bus.in_valid_in & ~skid_valid;
    assign out_fire = out_valid & bus.out_ready_in;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            out_valid  <= 1'b0;
            out_imm    <= '0;
            out_tag    <= '0;
            out_err    <= 1'b0;
            skid_valid <= 1'b0;
            skid_imm   <= '0;
            skid_tag   <= '0;
            skid_err   <= 1'b0;
        end else if (out_fire && skid_valid) begin
            // in_ready is low whenever SKID is full, so no input competes here
            out_imm    <= skid_imm;
            out_tag    <= skid_tag;
            out_err    <= skid_err;
            skid_valid <= 1'b0;
        end else if (in_fire && (!out_valid || out_fire)) begin
            out_valid <= 1'b1;
            out_imm   <= imm_c;
            out_tag   <= bus.tag_in;
            out_err   <= err_c;
        end else if (in_fire) begin
            skid_valid <= 1'b1;
            skid_imm   <= imm_c;
            skid_tag   <= bus.tag_in;
            skid_err   <= err_c;
        end else if (out_fire) begin
            out_valid <= 1'b0;
        end
    end

    assign bus.in_ready_out  = ~skid_valid;
    assign bus.out_valid_out = out_valid;
    assign bus.imm_out       = out_imm;
    assign bus.tag_out       = out_tag;
    assign bus.err_out       = out_err;
endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb/tb_imm_gen_pipe.sv - testbench for imm_gen_pipe at XLEN=32 and XLEN=64
module tb_imm_gen_pipe;
    typedef struct {
        logic [31:0] imm32;
        logic        err32;
        logic [63:0] imm64;
        logic        err64;
        logic [31:0] tag;
    } entry_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   nchk  = 0;
    int   nfail = 0;
    entry_t q[$];

    always #5 clk = ~clk;

    imm_gen_pipe_if #(.XLEN(32), .TAG_W(32)) b32 ();
    imm_gen_pipe_if #(.XLEN(64), .TAG_W(32)) b64 ();

    assign b64.instr_in     = b32.instr_in;
    assign b64.imm_type_in  = b32.imm_type_in;
    assign b64.tag_in       = b32.tag_in;
    assign b64.in_valid_in  = b32.in_valid_in;
    assign b64.out_ready_in = b32.out_ready_in;

    imm_gen_pipe #(.XLEN(32), .TAG_W(32)) dut32 (.clk_in(clk), .rst_in(rst), .bus(b32));
    imm_gen_pipe #(.XLEN(64), .TAG_W(32)) dut64 (.clk_in(clk), .rst_in(rst), .bus(b64));

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    function automatic longint sext(input longint val, input int bits);
        if (val >= (longint'(1) << (bits - 1)))
            return val - (longint'(1) << bits);
        return val;
    endfunction

    function automatic entry_t model(input logic [31:0] ins, input logic [3:0] t, input logic [31:0] tag);
        entry_t e;
        longint v32, v64;
        e.err32 = 1'b0;
        e.err64 = 1'b0;
        v32 = 0;
        case (t)
            4'd0, 4'd1, 4'd7: v32 = sext(longint'(ins[31:20]), 12);
            4'd2: v32 = sext(longint'(ins[31:25]) * 32 + longint'(ins[11:7]), 12);
            4'd3: v32 = sext(longint'(ins[31]) * 4096 + longint'(ins[7]) * 2048
                             + longint'(ins[30:25]) * 32 + longint'(ins[11:8]) * 2, 13);
            4'd4: v32 = sext(longint'(ins[31:12]) * 4096, 32);
            4'd5: v32 = sext(longint'(ins[31]) * 1048576 + longint'(ins[19:12]) * 4096
                             + longint'(ins[20]) * 2048 + longint'(ins[30:21]) * 2, 21);
            4'd6: v32 = longint'(ins[19:15]);
            4'd8: v32 = longint'(ins[24:20]);
            4'd9: v32 = 0;
            default: begin
                e.err32 = 1'b1;
                e.err64 = 1'b1;
            end
        endcase
        v64 = v32;
        if (t == 4'd8) begin
            e.err32 = ins[25];
            v64     = longint'(ins[25:20]);
        end
        e.imm32 = v32[31:0];
        e.imm64 = v64;
        e.tag   = tag;
        return e;
    endfunction

    task automatic tick();
        bit in_fire, out_fire;
        check("in_ready",     {63'd0, b32.in_ready_out},  {63'd0, q.size() < 2});
        check("out_valid",    {63'd0, b32.out_valid_out}, {63'd0, q.size() != 0});
        check("out_valid_64", {63'd0, b64.out_valid_out}, {63'd0, q.size() != 0});
        if (q.size() != 0) begin
            check("imm32", {32'd0, b32.imm_out}, {32'd0, q[0].imm32});
            check("err32", {63'd0, b32.err_out}, {63'd0, q[0].err32});
            check("tag",   {32'd0, b32.tag_out}, {32'd0, q[0].tag});
            check("imm64", b64.imm_out, q[0].imm64);
            check("err64", {63'd0, b64.err_out}, {63'd0, q[0].err64});
        end
        in_fire  = b32.in_valid_in && b32.in_ready_out;
        out_fire = b32.out_valid_out && b32.out_ready_in;
        @(posedge clk);
        if (rst) begin
            q.delete();
        end else begin
            if (out_fire && q.size() != 0) void'(q.pop_front());
            if (in_fire) q.push_back(model(b32.instr_in, b32.imm_type_in, b32.tag_in));
        end
        #1;
    endtask

    task automatic offer(input logic [3:0] t, input logic [31:0] ins, input logic [31:0] tag);
        b32.in_valid_in = 1'b1;
        b32.imm_type_in = t;
        b32.instr_in    = ins;
        b32.tag_in      = tag;
    endtask

    initial begin
        b32.in_valid_in  = 1'b0;
        b32.imm_type_in  = 4'd0;
        b32.instr_in     = 32'd0;
        b32.tag_in       = 32'd0;
        b32.out_ready_in = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_out_valid", {63'd0, b32.out_valid_out}, 64'd0);
        check("rst_in_ready",  {63'd0, b32.in_ready_out},  64'd1);
        check("rst_imm",       {32'd0, b32.imm_out},       64'd0);
        check("rst_tag",       {32'd0, b32.tag_out},       64'd0);
        check("rst_err",       {63'd0, b32.err_out},       64'd0);

        offer(4'd0, 32'hFFF00093, 32'h100);
        tick();
        b32.in_valid_in = 1'b0;
        check("addi_imm", {32'd0, b32.imm_out}, 64'hFFFFFFFF);
        check("addi_tag", {32'd0, b32.tag_out}, 64'h100);
        tick();

        offer(4'd2, 32'hFE20AE23, 32'h200);
        tick();
        check("sw_imm", {32'd0, b32.imm_out}, 64'hFFFFFFFC);
        offer(4'd5, 32'hFFDFF06F, 32'h201);
        tick();
        b32.in_valid_in = 1'b0;
        check("jal_imm", {32'd0, b32.imm_out}, 64'hFFFFFFFC);
        check("jal_tag", {32'd0, b32.tag_out}, 64'h201);
        tick();

        offer(4'd4, 32'h800000B7, 32'h300);
        tick();
        check("lui_imm32", {32'd0, b32.imm_out}, 64'h80000000);
        check("lui_imm64", b64.imm_out, 64'hFFFFFFFF80000000);
        offer(4'd8, 32'h02009093, 32'h301);
        tick();
        b32.in_valid_in = 1'b0;
        check("slli_imm32", {32'd0, b32.imm_out}, 64'd0);
        check("slli_err32", {63'd0, b32.err_out}, 64'd1);
        check("slli_imm64", b64.imm_out, 64'd32);
        check("slli_err64", {63'd0, b64.err_out}, 64'd0);
        tick();

        offer(4'd12, 32'h12345678, 32'h400);
        tick();
        check("rsvd_imm", {32'd0, b32.imm_out}, 64'd0);
        check("rsvd_err", {63'd0, b32.err_out}, 64'd1);
        offer(4'd9, 32'hFFFFFFFF, 32'h401);
        tick();
        check("zero_imm", {32'd0, b32.imm_out}, 64'd0);
        check("zero_err", {63'd0, b32.err_out}, 64'd0);
        offer(4'd6, 32'h000F8000, 32'h402);
        tick();
        b32.in_valid_in = 1'b0;
        check("zimm_imm", {32'd0, b32.imm_out}, 64'h1F);
        tick();

        b32.out_ready_in = 1'b0;
        offer(4'd0, 32'h00100093, 32'd1);
        tick();
        offer(4'd0, 32'h00200093, 32'd2);
        tick();
        check("bp_in_ready", {63'd0, b32.in_ready_out}, 64'd0);
        offer(4'd0, 32'h00300093, 32'd3);
        tick();
        tick();
        check("bp_hold_tag", {32'd0, b32.tag_out}, 64'd1);
        b32.out_ready_in = 1'b1;
        tick();
        check("bp_tag2", {32'd0, b32.tag_out}, 64'd2);
        tick();
        b32.in_valid_in = 1'b0;
        check("bp_tag3", {32'd0, b32.tag_out}, 64'd3);
        tick();
        tick();

        b32.out_ready_in = 1'b0;
        offer(4'd2, 32'hFE20AE23, 32'h11);
        tick();
        offer(4'd3, 32'hFE000EE3, 32'h12);
        tick();
        rst = 1'b1;
        offer(4'd0, 32'hFFF00093, 32'h13);
        tick();
        rst = 1'b0;
        b32.in_valid_in = 1'b0;
        check("mid_rst_out_valid", {63'd0, b32.out_valid_out}, 64'd0);
        check("mid_rst_in_ready",  {63'd0, b32.in_ready_out},  64'd1);
        check("mid_rst_imm",       {32'd0, b32.imm_out},       64'd0);
        check("mid_rst_tag",       {32'd0, b32.tag_out},       64'd0);
        check("mid_rst_err",       {63'd0, b32.err_out},       64'd0);
        b32.out_ready_in = 1'b1;
        repeat (3) tick();

        for (int i = 0; i < 500; i++) begin
            b32.in_valid_in  = ($urandom_range(0, 3) != 0);
            b32.out_ready_in = ($urandom_range(0, 2) != 0);
            b32.imm_type_in  = 4'($urandom_range(0, 15));
            b32.instr_in     = $urandom;
            b32.tag_in       = $urandom;
            tick();
        end
        b32.in_valid_in  = 1'b0;
        b32.out_ready_in = 1'b1;
        repeat (3) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end
endmodule
